zeroriscy_regfile_mp_sb: RTL and testbench
==========================================

// Module: zeroriscy_regfile_mp_sb
// PURPOSE
//  Flip-flop register file with NUM_RD read ports and NUM_WR write ports.
//  Adds a per-register pending scoreboard for long-latency writers (PPU/posit unit).
//  Generalises the fixed 3-read/1-write latch RF; x0 is hardwired to zero.
//  Sits in the ID stage: reads feed operand muxes; writeback and PPU drive write ports.
// PARAMETERS
//  RV32E       0   1: 16 regs (ADDR_WIDTH=4, addr bit 4 ignored); 0: 32 regs
//  DATA_WIDTH  32  register width
//  NUM_RD      3   read ports, 1..4
//  NUM_WR      2   write ports, 1..3; port NUM_WR-1 is the long-latency port (LL port)
//  BYPASS      1   1: reads forward same-cycle write data; 0: reads return stored value
// PORTS
//  clk          in   1                  clock, all state on rising edge
//  rst          in   1                  synchronous active-high reset
//  raddr_i      in   NUM_RD*5           read addresses, port r at [5r+:5]
//  rdata_o      out  NUM_RD*DATA_WIDTH  read data, port r at [DATA_WIDTH*r+:DATA_WIDTH]
//  rbusy_o      out  NUM_RD             read register pending (operand not yet valid)
//  waddr_i      in   NUM_WR*5           write addresses
//  wdata_i      in   NUM_WR*DATA_WIDTH  write data
//  we_i         in   NUM_WR             write enables
//  rsv_addr_i   in   5                  destination to reserve for LL op
//  rsv_en_i     in   1                  reserve request
//  rsv_ready_o  out  1                  reserve accepted this cycle if rsv_en_i
//  pend_cnt_o   out  ADDR_WIDTH+1       number of pending registers
// BEHAVIOUR
//  Reset: all regs 0, all pending bits 0, pend_cnt_o=0; rsv_ready_o=1; rbusy_o=0;
//   rdata_o=0 (or bypassed wdata if BYPASS and we_i set during reset cycle: reset wins
//   at the edge, state stays 0). Reset mid-operation discards writes/reserves that cycle.
//  Address: a_int = addr[ADDR_WIDTH-1:0]; a_int==0 -> read returns 0, write ignored,
//   reserve ignored (rsv_ready_o=1, no pending set, count unchanged).
//  Write: on edge, each port p with we_i[p] & a_int!=0 updates reg. Same address on
//   several ports: highest port index wins. Latency 1 cycle.
//  Read: combinational. BYPASS=1: if any enabled write targets raddr (!=0), rdata_o =
//   wdata of highest such port; else stored value. BYPASS=0: stored value only.
//  Scoreboard: pending[k] set on edge when rsv_en_i & rsv_ready_o & rsv_addr=k (k!=0).
//   Cleared on edge when we_i[NUM_WR-1] & waddr LL port = k. Other ports never clear.
//   Reserve and LL clear same reg same cycle: reserve wins, pending stays 1.
//  rsv_ready_o = ~pending[rsv_a_int] | (rsv_a_int==0) (WAW on pending reg refused; no
//   look-ahead on same-cycle clear).
//  rbusy_o[r] = pending[raddr_r]; BYPASS=1: forced 0 when LL port writes that reg
//   this cycle (data forwarded). raddr 0 never busy.
//  pend_cnt_o registered: +1 accepted reserve of non-pending reg, -1 clear of pending
//   reg; both on different regs -> net 0; same reg -> unchanged. Never wraps
//   (max 2**ADDR_WIDTH-1 by construction); LL write to non-pending reg: no decrement.
//  Non-LL write to pending reg: data updated, pending unchanged (allowed, not flagged).
// STRUCTURE
//  Package zeroriscy_rf_pkg: RF_ADDR_W=5, function addr_width(rv32e), typedef
//   rf_addr_t, constant LL port index helper.
//  Sub-module zeroriscy_rf_scoreboard: pending vector, rsv_ready_o, pend_cnt_o, busy
//   lookup; top holds storage array, write priority and bypass muxes.
//  Assertions: pending[0]==0 always; pend_cnt_o == $countones(pending).
// TESTING
//  1 Reset, write x5=0xDEADBEEF port0; next cycle raddr0=5 -> 0xDEADBEEF; BYPASS=1 same
//    cycle read -> 0xDEADBEEF, BYPASS=0 -> 0.
//  2 Ports 0,1 both write x7 (0x11,0x22) -> x7=0x22; write x0=0xFF -> read x0=0.
//  3 Reserve x9 -> pend_cnt=1, rbusy on raddr=9; reserve x9 again -> rsv_ready_o=0,
//    count stays 1; LL write x9=0x1234 -> rbusy 0 same cycle (BYPASS=1), count 0.
//  4 Same cycle reserve x3 and LL clear x3 (pending) -> pending stays 1, count unchanged;
//    reserve x4 + clear x3 -> count unchanged, x4 pending, x3 free.
//  5 RV32E=1: write addr 0x13 -> lands in x3; reserve addr 0x10 -> ignored (maps to x0).
//  6 Reserve x1,x2,x3 then assert rst with LL write x1 -> all regs 0, count 0, no busy.

Source files
------------

// File: rtl/zeroriscy_rf_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
// Port 0 of the write side is the writeback path; the last port is the long-latency (PPU) path.
package zeroriscy_rf_pkg;

  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  function automatic int addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

  function automatic int ll_port(input int num_wr);
    return num_wr - 1;
  endfunction

endpackage

// File: rtl/zeroriscy_rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: reserve, clear, busy lookup
// and a registered count of outstanding registers.
module zeroriscy_rf_scoreboard
  import zeroriscy_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 3,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RD-1:0]            rbusy_o,
  input  logic                         ll_we_i,
  input  logic [ADDR_WIDTH-1:0]        ll_waddr_i,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr_i,
  input  logic                         rsv_en_i,
  output logic                         rsv_ready_o,
  output logic [ADDR_WIDTH:0]          pend_cnt_o
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [NREG-1:0]     r_pend;
  logic [ADDR_WIDTH:0] r_cnt;
  logic                w_take;
  logic                w_clr_ok;
  logic                w_clr;

  assign rsv_ready_o = ~r_pend[rsv_addr_i] | (rsv_addr_i == '0);
  assign w_take      = rsv_en_i & rsv_ready_o & (rsv_addr_i != '0);
  // A reserve request on the same register masks the LL clear, even when refused.
  assign w_clr_ok    = ll_we_i & ~(rsv_en_i & (rsv_addr_i == ll_waddr_i));
  assign w_clr       = w_clr_ok & r_pend[ll_waddr_i];
  assign pend_cnt_o  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_clr_ok) r_pend[ll_waddr_i] <= 1'b0;
      if (w_take)   r_pend[rsv_addr_i] <= 1'b1;
      case ({w_take, w_clr})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    rbusy_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rbusy_o[r] = r_pend[raddr_i[ADDR_WIDTH*r +: ADDR_WIDTH]];
      if (BYPASS && ll_we_i && (ll_waddr_i == raddr_i[ADDR_WIDTH*r +: ADDR_WIDTH]))
        rbusy_o[r] = 1'b0;
    end
  end

  a_pend0_zero: assert property (@(posedge clk) r_pend[0] == 1'b0);
  a_cnt_match:  assert property (@(posedge clk) disable iff (rst)
                                 int'(pend_cnt_o) == $countones(r_pend));

endmodule

// File: rtl/zeroriscy_regfile_mp_sb.sv
// Flip-flop register file, NUM_RD read / NUM_WR write ports, x0 hardwired to zero,
// optional same-cycle write forwarding, scoreboard for the long-latency write port.
module zeroriscy_regfile_mp_sb
  import zeroriscy_rf_pkg::*;
#(
  parameter bit RV32E      = 1'b0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter bit BYPASS     = 1'b1,
  localparam int ADDR_WIDTH = addr_width(RV32E)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*RF_ADDR_W-1:0]  raddr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RD-1:0]            rbusy_o,
  input  logic [NUM_WR*RF_ADDR_W-1:0]  waddr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WR-1:0]            we_i,
  input  rf_addr_t                     rsv_addr_i,
  input  logic                         rsv_en_i,
  output logic                         rsv_ready_o,
  output logic [ADDR_WIDTH:0]          pend_cnt_o
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int LL   = ll_port(NUM_WR);

  logic [ADDR_WIDTH-1:0]        w_wa [NUM_WR];
  logic [NUM_WR-1:0]            w_we;
  logic [ADDR_WIDTH-1:0]        w_ra [NUM_RD];
  logic [NUM_RD*ADDR_WIDTH-1:0] w_ra_flat;
  logic [DATA_WIDTH-1:0]        r_regs [NREG];
  logic                         w_unused_hi;

  // Effective addresses; writes to x0 are dropped here so nothing downstream sees them.
  always_comb begin
    w_we      = '0;
    w_ra_flat = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      w_wa[p] = waddr_i[RF_ADDR_W*p +: ADDR_WIDTH];
      w_we[p] = we_i[p] & (w_wa[p] != '0);
    end
    for (int r = 0; r < NUM_RD; r++) begin
      w_ra[r] = raddr_i[RF_ADDR_W*r +: ADDR_WIDTH];
      w_ra_flat[ADDR_WIDTH*r +: ADDR_WIDTH] = w_ra[r];
    end
  end

  always_comb begin
    w_unused_hi = rsv_addr_i[RF_ADDR_W-1];
    for (int r = 0; r < NUM_RD; r++) w_unused_hi ^= raddr_i[RF_ADDR_W*r + RF_ADDR_W-1];
    for (int p = 0; p < NUM_WR; p++) w_unused_hi ^= waddr_i[RF_ADDR_W*p + RF_ADDR_W-1];
  end

  // Later ports overwrite earlier ones, so the highest port index wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (w_we[p]) r_regs[w_wa[p]] <= wdata_i[DATA_WIDTH*p +: DATA_WIDTH];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (w_ra[r] != '0) rdata_o[DATA_WIDTH*r +: DATA_WIDTH] = r_regs[w_ra[r]];
      if (BYPASS) begin
        for (int p = 0; p < NUM_WR; p++)
          if (w_we[p] && (w_wa[p] == w_ra[r]))
            rdata_o[DATA_WIDTH*r +: DATA_WIDTH] = wdata_i[DATA_WIDTH*p +: DATA_WIDTH];
      end
    end
  end

  zeroriscy_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .BYPASS     (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .raddr_i     (w_ra_flat),
    .rbusy_o     (rbusy_o),
    .ll_we_i     (w_we[LL]),
    .ll_waddr_i  (w_wa[LL]),
    .rsv_addr_i  (rsv_addr_i[ADDR_WIDTH-1:0]),
    .rsv_en_i    (rsv_en_i),
    .rsv_ready_o (rsv_ready_o),
    .pend_cnt_o  (pend_cnt_o)
  );

endmodule

// File: tb/tb_zeroriscy_regfile_mp_sb.sv
// Bench for the multi-port register file: one RV32I/bypass instance and one RV32E/no-bypass
// instance share stimulus; a reference model feeds a scoreboard checked every cycle.
module tb_zeroriscy_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic [4:0]  rsv_addr;
  logic        rsv_en;

  logic [95:0] rdata_a, rdata_e;
  logic [2:0]  rbusy_a, rbusy_e;
  logic        rdy_a, rdy_e;
  logic [5:0]  cnt_a;
  logic [4:0]  cnt_e;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [95:0] rd;
    logic [2:0]  bz;
    logic        rr;
    logic [5:0]  pc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_reg  [2][32];
  bit          m_pend [2][32];

  always #5 clk = ~clk;

  zeroriscy_regfile_mp_sb #(.RV32E(1'b0), .DATA_WIDTH(32), .NUM_RD(3), .NUM_WR(2), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_addr_i(rsv_addr), .rsv_en_i(rsv_en),
    .rsv_ready_o(rdy_a), .pend_cnt_o(cnt_a));

  zeroriscy_regfile_mp_sb #(.RV32E(1'b1), .DATA_WIDTH(32), .NUM_RD(3), .NUM_WR(2), .BYPASS(1'b0)) u_dut_e (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_e), .rbusy_o(rbusy_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_addr_i(rsv_addr), .rsv_en_i(rsv_en),
    .rsv_ready_o(rdy_e), .pend_cnt_o(cnt_e));

  // Instance 0: 32 regs, forwarding. Instance 1: 16 regs, no forwarding.
  function automatic exp_t model_expect(input int i);
    exp_t e;
    int   m, a, la, c;
    m  = (i == 0) ? 31 : 15;
    e  = '0;
    la = int'(waddr[9:5]) & m;
    for (int r = 0; r < 3; r++) begin
      a = int'(raddr[5*r +: 5]) & m;
      if (a != 0) begin
        e.rd[32*r +: 32] = m_reg[i][a];
        if (i == 0)
          for (int p = 0; p < 2; p++)
            if (we[p] && ((int'(waddr[5*p +: 5]) & m) == a)) e.rd[32*r +: 32] = wdata[32*p +: 32];
        e.bz[r] = m_pend[i][a] && !(i == 0 && we[1] && la == a);
      end
    end
    a    = int'(rsv_addr) & m;
    e.rr = (a == 0) || !m_pend[i][a];
    c    = 0;
    for (int k = 0; k < 32; k++) c += int'(m_pend[i][k]);
    e.pc = 6'(c);
    return e;
  endfunction

  function automatic void model_edge(input int i);
    int m, a, ra, la;
    bit take;
    m    = (i == 0) ? 31 : 15;
    ra   = int'(rsv_addr) & m;
    la   = int'(waddr[9:5]) & m;
    take = rsv_en && (ra != 0) && !m_pend[i][ra];
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        m_reg[i][k]  = '0;
        m_pend[i][k] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        a = int'(waddr[5*p +: 5]) & m;
        if (we[p] && a != 0) m_reg[i][a] = wdata[32*p +: 32];
      end
      if (we[1] && la != 0 && !(rsv_en && ra == la)) m_pend[i][la] = 1'b0;
      if (take) m_pend[i][ra] = 1'b1;
    end
  endfunction

  task automatic step();
    if (!rst) begin
      q.push_back(model_expect(0));
      q.push_back(model_expect(1));
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic monitor();
    exp_t ea, ee;
    forever begin
      @(negedge clk);
      if (q.size() >= 2) begin
        ea = q.pop_front();
        ee = q.pop_front();
        checks++; if (rdata_a !== ea.rd) begin errors++; $display("FAIL sb_rdata_a t=%0t got %h exp %h", $time, rdata_a, ea.rd); end
        checks++; if (rbusy_a !== ea.bz) begin errors++; $display("FAIL sb_rbusy_a t=%0t got %b exp %b", $time, rbusy_a, ea.bz); end
        checks++; if (rdy_a !== ea.rr) begin errors++; $display("FAIL sb_ready_a t=%0t got %b exp %b", $time, rdy_a, ea.rr); end
        checks++; if (cnt_a !== ea.pc) begin errors++; $display("FAIL sb_cnt_a t=%0t got %0d exp %0d", $time, cnt_a, ea.pc); end
        checks++; if (rdata_e !== ee.rd) begin errors++; $display("FAIL sb_rdata_e t=%0t got %h exp %h", $time, rdata_e, ee.rd); end
        checks++; if (rbusy_e !== ee.bz) begin errors++; $display("FAIL sb_rbusy_e t=%0t got %b exp %b", $time, rbusy_e, ee.bz); end
        checks++; if (rdy_e !== ee.rr) begin errors++; $display("FAIL sb_ready_e t=%0t got %b exp %b", $time, rdy_e, ee.rr); end
        checks++; if ({1'b0, cnt_e} !== ee.pc) begin errors++; $display("FAIL sb_cnt_e t=%0t got %0d exp %0d", $time, cnt_e, ee.pc); end
      end
    end
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic setw(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1; waddr[5*p +: 5] = a; wdata[32*p +: 32] = d;
  endtask

  task automatic setr(input int r, input logic [4:0] a);
    raddr[5*r +: 5] = a;
  endtask

  task automatic reserve(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    step(); step();
    rst = 1'b0;
    setr(0, 5'd5); setr(1, 5'd7); setr(2, 5'd9);
    #1;
    checks++; if (rdata_a !== 96'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_a); end
    checks++; if (cnt_a !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_a); end
    checks++; if (rbusy_a !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", rbusy_a); end
    step();
  endtask

  task automatic test_write_read();
    idle(); setw(0, 5'd5, 32'hDEADBEEF); setr(0, 5'd5);
    #1;
    checks++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp deadbeef", rdata_a[31:0]); end
    checks++; if (rdata_e[31:0] !== 32'h0) begin errors++; $display("FAIL nobypass_same_cycle got %h exp 0", rdata_e[31:0]); end
    step();
    idle(); setr(0, 5'd5);
    #1;
    checks++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_after_write_a got %h exp deadbeef", rdata_a[31:0]); end
    checks++; if (rdata_e[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_after_write_e got %h exp deadbeef", rdata_e[31:0]); end
    step();
  endtask

  task automatic test_priority();
    idle(); setw(0, 5'd7, 32'h11); setw(1, 5'd7, 32'h22); setr(2, 5'd7);
    #1;
    checks++; if (rdata_a[95:64] !== 32'h22) begin errors++; $display("FAIL bypass_priority got %h exp 22", rdata_a[95:64]); end
    step();
    idle(); setw(0, 5'd0, 32'hFF); setr(0, 5'd7); setr(1, 5'd0);
    #1;
    checks++; if (rdata_e[31:0] !== 32'h22) begin errors++; $display("FAIL write_priority got %h exp 22", rdata_e[31:0]); end
    checks++; if (rdata_a[63:32] !== 32'h0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rdata_a[63:32]); end
    step();
    idle(); setr(1, 5'd0);
    #1;
    checks++; if (rdata_a[63:32] !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp 0", rdata_a[63:32]); end
    step();
  endtask

  task automatic test_scoreboard();
    idle(); reserve(5'd9);
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rsv_first_ready got %b exp 1", rdy_a); end
    step();
    idle(); setr(0, 5'd9); reserve(5'd9);
    #1;
    checks++; if (rbusy_a[0] !== 1'b1) begin errors++; $display("FAIL rsv_busy got %b exp 1", rbusy_a[0]); end
    checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL rsv_cnt got %0d exp 1", cnt_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rsv_waw_refused got %b exp 0", rdy_a); end
    step();
    idle(); setr(0, 5'd9); setw(1, 5'd9, 32'h1234);
    #1;
    checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL rsv_cnt_hold got %0d exp 1", cnt_a); end
    checks++; if (rbusy_a[0] !== 1'b0) begin errors++; $display("FAIL ll_busy_bypass got %b exp 0", rbusy_a[0]); end
    checks++; if (rbusy_e[0] !== 1'b1) begin errors++; $display("FAIL ll_busy_nobypass got %b exp 1", rbusy_e[0]); end
    checks++; if (rdata_a[31:0] !== 32'h1234) begin errors++; $display("FAIL ll_fwd_data got %h exp 1234", rdata_a[31:0]); end
    step();
    idle();
    #1;
    checks++; if (cnt_a !== 6'd0) begin errors++; $display("FAIL ll_clear_cnt got %0d exp 0", cnt_a); end
    step();
  endtask

  task automatic test_same_cycle();
    idle(); reserve(5'd3);
    step();
    idle(); reserve(5'd3); setw(1, 5'd3, 32'h33);
    step();
    idle(); setr(0, 5'd3);
    #1;
    checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL rsv_vs_clr_cnt got %0d exp 1", cnt_a); end
    checks++; if (rbusy_a[0] !== 1'b1) begin errors++; $display("FAIL rsv_vs_clr_pend got %b exp 1", rbusy_a[0]); end
    step();
    idle(); reserve(5'd4); setw(1, 5'd3, 32'h34);
    step();
    idle(); setr(0, 5'd4); setr(1, 5'd3);
    #1;
    checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL rsv_and_clr_cnt got %0d exp 1", cnt_a); end
    checks++; if (rbusy_a[1:0] !== 2'b01) begin errors++; $display("FAIL rsv_and_clr_busy got %b exp 01", rbusy_a[1:0]); end
    step();
  endtask

  task automatic test_rv32e();
    idle(); setw(0, 5'h13, 32'hABCD);
    step();
    idle(); setr(0, 5'h03); setr(1, 5'h13); reserve(5'h10);
    #1;
    checks++; if (rdata_e[31:0] !== 32'hABCD) begin errors++; $display("FAIL rv32e_alias_x3 got %h exp abcd", rdata_e[31:0]); end
    checks++; if (rdata_a[63:32] !== 32'hABCD) begin errors++; $display("FAIL rv32i_x19 got %h exp abcd", rdata_a[63:32]); end
    checks++; if (rdy_e !== 1'b1) begin errors++; $display("FAIL rv32e_rsv_x0_ready got %b exp 1", rdy_e); end
    step();
    idle();
    #1;
    checks++; if (cnt_e !== 5'd1) begin errors++; $display("FAIL rv32e_rsv_x0_cnt got %0d exp 1", cnt_e); end
    checks++; if (cnt_a !== 6'd2) begin errors++; $display("FAIL rv32i_rsv_x16_cnt got %0d exp 2", cnt_a); end
    step();
  endtask

  task automatic test_reset_mid();
    idle(); reserve(5'd1); step();
    idle(); reserve(5'd2); step();
    idle(); reserve(5'd3); step();
    rst = 1'b1; idle(); setw(1, 5'd1, 32'h55); reserve(5'd5);
    step();
    rst = 1'b0; idle(); setr(0, 5'd1); setr(1, 5'd2); setr(2, 5'd7);
    #1;
    checks++; if (rdata_a !== 96'h0) begin errors++; $display("FAIL rst_mid_rdata got %h exp 0", rdata_a); end
    checks++; if (cnt_a !== 6'd0 || cnt_e !== 5'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d/%0d exp 0/0", cnt_a, cnt_e); end
    checks++; if (rbusy_a !== 3'b000 || rbusy_e !== 3'b000) begin errors++; $display("FAIL rst_mid_busy got %b/%b exp 000", rbusy_a, rbusy_e); end
    step();
  endtask

  function automatic logic [4:0] rnd_addr();
    logic [4:0] a;
    a = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a = a | 5'h10;
    return a;
  endfunction

  task automatic test_back_to_back();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 2) == 0) setw(p, rnd_addr(), $urandom());
      for (int r = 0; r < 3; r++) setr(r, rnd_addr());
      if ($urandom_range(0, 1) == 0) reserve(rnd_addr());
      step();
    end
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    fork
      monitor();
    join_none
    #1;
    test_reset();
    test_write_read();
    test_priority();
    test_scoreboard();
    test_same_cycle();
    test_rv32e();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
